// File: rtl/wash_phase_controller.sv
// Washing-machine cycle controller: power-on init countdown, idle, wash/rinse/spin
// phases with programmable durations and rinse repeats, pause/resume with door
// interlock, finish alarm and power-off. All timing comes from an internal tick
// prescaler driving a shared per-state countdown (remain).
module wash_phase_controller #(
  parameter int TIME_W      = 4,
  parameter int TICK_DIV    = 2,
  parameter int INIT_TIME   = 5,
  parameter int FINISH_TIME = 5
) (
  input  logic              cp,
  input  logic              resetBtn,
  input  logic              runBtn,
  input  logic              openBtn,
  input  logic [2:0]        modeSel,
  input  logic [TIME_W-1:0] washTime,
  input  logic [TIME_W-1:0] rinseTime,
  input  logic [TIME_W-1:0] spinTime,
  input  logic [1:0]        rinseCnt,
  output logic [2:0]        state,
  output logic [TIME_W-1:0] remain,
  output logic [1:0]        rinseLeft,
  output logic              doorLock,
  output logic              beep
);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_WASH   = 3'd2,
    ST_RINSE  = 3'd3,
    ST_SPIN   = 3'd4,
    ST_PAUSE  = 3'd5,
    ST_FINISH = 3'd6,
    ST_OFF    = 3'd7
  } state_t;

  // Where the phase search starts: the next candidate after the given point.
  localparam logic [1:0] FROM_START = 2'd0;
  localparam logic [1:0] FROM_WASH  = 2'd1;
  localparam logic [1:0] FROM_RINSE = 2'd2;
  localparam logic [1:0] FROM_SPIN  = 2'd3;

  localparam int                PRESC_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [TIME_W-1:0] INIT_LOAD   = TIME_W'(INIT_TIME);
  localparam logic [TIME_W-1:0] FINISH_LOAD = TIME_W'(FINISH_TIME);
  localparam logic [TIME_W-1:0] ONE         = TIME_W'(1);

  state_t              state_reg, state_next;
  state_t              saved_reg, saved_next;
  logic [PRESC_W-1:0]  presc_reg, presc_next;
  logic                run_prev_reg;
  logic [TIME_W-1:0]   remain_reg, remain_next;
  logic [1:0]          rinse_left_reg, rinse_left_next;
  logic                door_lock_reg, door_lock_next;
  logic                beep_reg, beep_next;
  logic [2:0]          mode_reg, mode_next;
  logic [TIME_W-1:0]   wash_t_reg, wash_t_next;
  logic [TIME_W-1:0]   rinse_t_reg, rinse_t_next;
  logic [TIME_W-1:0]   spin_t_reg, spin_t_next;
  logic [1:0]          rinse_cnt_reg, rinse_cnt_next;

  logic                tick;
  logic                run_edge;
  logic                enter_en;
  logic [1:0]          enter_from;
  state_t              enter_tgt;

  // In IDLE the live inputs are the configuration being latched this edge;
  // everywhere else only the latched copy counts.
  logic [2:0]          cfg_mode;
  logic [TIME_W-1:0]   cfg_wash, cfg_rinse, cfg_spin;
  logic [1:0]          cfg_rcnt;

  assign tick      = (presc_reg == PRESC_LAST);
  assign run_edge  = runBtn & ~run_prev_reg;
  assign cfg_mode  = (state_reg == ST_IDLE) ? modeSel   : mode_reg;
  assign cfg_wash  = (state_reg == ST_IDLE) ? washTime  : wash_t_reg;
  assign cfg_rinse = (state_reg == ST_IDLE) ? rinseTime : rinse_t_reg;
  assign cfg_spin  = (state_reg == ST_IDLE) ? spinTime  : spin_t_reg;
  assign cfg_rcnt  = (state_reg == ST_IDLE) ? rinseCnt  : rinse_cnt_reg;

  // First enabled, non-zero-length phase after the given point; FINISH if none.
  function automatic state_t pick_phase(input logic [1:0]        from,
                                        input logic [2:0]        mode,
                                        input logic [TIME_W-1:0] wt,
                                        input logic [TIME_W-1:0] rt,
                                        input logic [TIME_W-1:0] st,
                                        input logic [1:0]        rc);
    state_t res;
    res = ST_FINISH;
    if (from <= FROM_RINSE && mode[2] && st != '0) res = ST_SPIN;
    if (from <= FROM_WASH && mode[1] && rt != '0 && rc != 2'd0) res = ST_RINSE;
    if (from == FROM_START && mode[0] && wt != '0) res = ST_WASH;
    return res;
  endfunction

  // Next-state and next-output computation for the whole cycle.
  always_comb begin
    state_next      = state_reg;
    saved_next      = saved_reg;
    remain_next     = remain_reg;
    rinse_left_next = rinse_left_reg;
    door_lock_next  = door_lock_reg;
    beep_next       = beep_reg;
    mode_next       = mode_reg;
    wash_t_next     = wash_t_reg;
    rinse_t_next    = rinse_t_reg;
    spin_t_next     = spin_t_reg;
    rinse_cnt_next  = rinse_cnt_reg;
    enter_en        = 1'b0;
    enter_from      = FROM_START;
    enter_tgt       = ST_FINISH;

    case (state_reg)
      ST_INIT: begin
        if (tick) begin
          if (remain_reg == ONE) begin
            state_next  = ST_IDLE;
            remain_next = '0;
          end else begin
            remain_next = remain_reg - ONE;
          end
        end
      end

      ST_IDLE: begin
        if (run_edge && !openBtn && modeSel != 3'd0) begin
          mode_next      = modeSel;
          wash_t_next    = washTime;
          rinse_t_next   = rinseTime;
          spin_t_next    = spinTime;
          rinse_cnt_next = rinseCnt;
          door_lock_next = 1'b1;
          enter_en       = 1'b1;
          enter_from     = FROM_START;
        end
      end

      ST_WASH, ST_RINSE, ST_SPIN: begin
        // A pause request wins over an expiry on the same edge.
        if (run_edge) begin
          state_next = ST_PAUSE;
          saved_next = state_reg;
        end else if (tick) begin
          if (remain_reg != ONE) begin
            remain_next = remain_reg - ONE;
          end else if (state_reg == ST_RINSE && rinse_left_reg > 2'd1) begin
            rinse_left_next = rinse_left_reg - 2'd1;
            remain_next     = rinse_t_reg;
          end else begin
            rinse_left_next = 2'd0;
            enter_en        = 1'b1;
            case (state_reg)
              ST_WASH:  enter_from = FROM_WASH;
              ST_RINSE: enter_from = FROM_RINSE;
              default:  enter_from = FROM_SPIN;
            endcase
          end
        end
      end

      ST_PAUSE: begin
        door_lock_next = ~openBtn;
        if (run_edge && !openBtn) begin
          state_next     = saved_reg;
          door_lock_next = 1'b1;
        end
      end

      ST_FINISH: begin
        if (tick) begin
          if (remain_reg == ONE) begin
            state_next      = ST_OFF;
            remain_next     = '0;
            beep_next       = 1'b0;
            door_lock_next  = 1'b0;
            rinse_left_next = 2'd0;
          end else begin
            remain_next = remain_reg - ONE;
          end
        end
      end

      default: begin
        remain_next     = '0;
        rinse_left_next = 2'd0;
        door_lock_next  = 1'b0;
        beep_next       = 1'b0;
      end
    endcase

    // Phase entry, including same-edge skipping of disabled/empty phases.
    if (enter_en) begin
      enter_tgt  = pick_phase(enter_from, cfg_mode, cfg_wash, cfg_rinse, cfg_spin, cfg_rcnt);
      state_next = enter_tgt;
      case (enter_tgt)
        ST_WASH:  remain_next = cfg_wash;
        ST_RINSE: begin
          remain_next     = cfg_rinse;
          rinse_left_next = cfg_rcnt;
        end
        ST_SPIN:  remain_next = cfg_spin;
        default: begin
          remain_next    = FINISH_LOAD;
          beep_next      = 1'b1;
          door_lock_next = 1'b0;
        end
      endcase
    end

    // Restarting the prescaler on every state change makes each state last
    // exactly its load value times TICK_DIV, and discards a pending tick on pause.
    if (tick || state_next != state_reg) presc_next = '0;
    else                                 presc_next = presc_reg + PRESC_ONE;
  end

  // State and registered outputs; reset takes effect without a clock.
  always_ff @(posedge cp or negedge resetBtn) begin
    if (!resetBtn) begin
      state_reg      <= ST_INIT;
      saved_reg      <= ST_WASH;
      presc_reg      <= '0;
      run_prev_reg   <= 1'b0;
      remain_reg     <= INIT_LOAD;
      rinse_left_reg <= 2'd0;
      door_lock_reg  <= 1'b0;
      beep_reg       <= 1'b0;
      mode_reg       <= 3'd0;
      wash_t_reg     <= '0;
      rinse_t_reg    <= '0;
      spin_t_reg     <= '0;
      rinse_cnt_reg  <= 2'd0;
    end else begin
      state_reg      <= state_next;
      saved_reg      <= saved_next;
      presc_reg      <= presc_next;
      run_prev_reg   <= runBtn;
      remain_reg     <= remain_next;
      rinse_left_reg <= rinse_left_next;
      door_lock_reg  <= door_lock_next;
      beep_reg       <= beep_next;
      mode_reg       <= mode_next;
      wash_t_reg     <= wash_t_next;
      rinse_t_reg    <= rinse_t_next;
      spin_t_reg     <= spin_t_next;
      rinse_cnt_reg  <= rinse_cnt_next;
    end
  end

  assign state     = state_reg;
  assign remain    = remain_reg;
  assign rinseLeft = rinse_left_reg;
  assign doorLock  = door_lock_reg;
  assign beep      = beep_reg;

endmodule
